ntt_stage_ctrl: RTL and testbench



---
 rtl/ntt_ctrl_pkg.sv | 36 +++
 rtl/ntt_wb_delay.sv | 50 +++++
 rtl/ntt_stage_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ntt_ctrl_pkg.sv
// ntt_ctrl_pkg: shared definitions for the NTT stage controller.
//   - `D_width      : coefficient / modulus width (default 32 when not set by the build)
//   - ntt_state_t    : FSM state encoding, with StIdle/StRun/StDrain/StDone constants
//   - drain_len()    : pipeline drain length, RAM read latency plus butterfly latency
//   - ntt_addr_t     : coefficient address type for the default transform length

`ifndef D_width
`define D_width 32
`endif

package ntt_ctrl_pkg;

    // Default configuration, used as the controller's parameter defaults.
    localparam int unsigned NttNDef     = 1024;
    localparam int unsigned NttLogNDef  = $clog2(NttNDef);
    localparam int unsigned NttRdLatDef = 1;
    localparam int unsigned NttBuLatDef = 2;

    typedef logic [NttLogNDef-1:0] ntt_addr_t;

    // Kept as plain constants so older code that compares raw state bits keeps working.
    typedef logic [1:0] ntt_state_t;
    localparam ntt_state_t StIdle  = 2'd0;
    localparam ntt_state_t StRun   = 2'd1;
    localparam ntt_state_t StDrain = 2'd2;
    localparam ntt_state_t StDone  = 2'd3;

    // Cycles from a read strobe to the matching butterfly outputs.
    function automatic int unsigned drain_len(input int unsigned rd_lat,
                                              input int unsigned bu_lat);
        return rd_lat + bu_lat;
    endfunction

    localparam int unsigned NttDrainDef = drain_len(NttRdLatDef, NttBuLatDef);

endpackage

// File: rtl/ntt_wb_delay.sv
// ntt_wb_delay: DEPTH-stage shift register that turns a read issue into the matching
// write-back strobe once the RAM read and the butterfly have completed.
//   clk, rst                      : clock, synchronous active-high reset (clears every stage)
//   in_valid, in_addr_a/b         : read strobe and read addresses at issue time
//   out_valid, out_addr_a/b       : the same values delayed by exactly DEPTH cycles

module ntt_wb_delay
    import ntt_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = NttDrainDef,
    parameter int unsigned AW    = NttLogNDef
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr_a,
    input  logic [AW-1:0] in_addr_b,
    output logic          out_valid,
    output logic [AW-1:0] out_addr_a,
    output logic [AW-1:0] out_addr_b
);

    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    addr_a_q [DEPTH];
    logic [AW-1:0]    addr_b_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_a_q[i] <= '0;
                addr_b_q[i] <= '0;
            end
        end else begin
            valid_q[0]  <= in_valid;
            addr_a_q[0] <= in_addr_a;
            addr_b_q[0] <= in_addr_b;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i]  <= valid_q[i-1];
                addr_a_q[i] <= addr_a_q[i-1];
                addr_b_q[i] <= addr_b_q[i-1];
            end
        end
    end

    assign out_valid  = valid_q[DEPTH-1];
    assign out_addr_a = addr_a_q[DEPTH-1];
    assign out_addr_b = addr_b_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: sequences one in-place forward negacyclic NTT (Cooley-Tukey,
// bit-reversed twiddles) of N coefficients through a single butterfly.
//   clk, rst            : clock, synchronous active-high reset (aborts any transform)
//   start, modulus_in   : one-cycle request and modulus, accepted only when idle
//   busy, done          : busy through the last drain cycle; done pulses once at the end
//   rd_en, rd_addr_a/b  : coefficient reads j and j+t, one butterfly per cycle
//   tw_addr             : twiddle-ROM index m+i
//   modulus             : modulus latched at start, held until the next start
//   wr_en, wr_addr_a/b  : write-back of the butterfly outputs, D cycles after the read

module ntt_stage_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int unsigned N      = NttNDef,
    parameter int unsigned LOG_N  = $clog2(N),
    parameter int unsigned RD_LAT = NttRdLatDef,
    parameter int unsigned BU_LAT = NttBuLatDef
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [`D_width-1:0] modulus_in,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [LOG_N-1:0]    rd_addr_a,
    output logic [LOG_N-1:0]    rd_addr_b,
    output logic [LOG_N-1:0]    tw_addr,
    output logic [`D_width-1:0] modulus,
    output logic                wr_en,
    output logic [LOG_N-1:0]    wr_addr_a,
    output logic [LOG_N-1:0]    wr_addr_b
);

    localparam int unsigned D  = drain_len(RD_LAT, BU_LAT);
    localparam int unsigned DW = $clog2(D + 1);

    localparam logic [LOG_N-1:0] AddrOne   = LOG_N'(1);
    localparam logic [LOG_N-1:0] HalfN     = LOG_N'(N / 2);
    localparam logic [LOG_N-1:0] LastStage = LOG_N'(LOG_N - 1);
    localparam logic [DW-1:0]    LastDrain = DW'(D - 1);

    ntt_state_t          state_q, state_d;
    logic [LOG_N-1:0]    stage_q, stage_d;
    logic [LOG_N-1:0]    m_q, m_d;        // groups in this stage, 2^s
    logic [LOG_N-1:0]    t_q, t_d;        // butterfly span, N >> (s+1)
    logic [LOG_N-1:0]    i_q, i_d;        // group index
    logic [LOG_N-1:0]    k_q, k_d;        // offset inside the group
    logic [LOG_N-1:0]    base_q, base_d;  // 2*i*t, kept incrementally
    logic [DW-1:0]       drain_q, drain_d;
    logic [`D_width-1:0] mod_q, mod_d;

    logic last_k, last_i, last_stage, drain_end;

    assign last_k     = (k_q == t_q - AddrOne);
    assign last_i     = (i_q == m_q - AddrOne);
    assign last_stage = (stage_q == LastStage);
    assign drain_end  = (drain_q == LastDrain);

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        m_d     = m_q;
        t_d     = t_q;
        i_d     = i_q;
        k_d     = k_q;
        base_d  = base_q;
        drain_d = drain_q;
        mod_d   = mod_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    stage_d = '0;
                    m_d     = AddrOne;
                    t_d     = HalfN;
                    i_d     = '0;
                    k_d     = '0;
                    base_d  = '0;
                    drain_d = '0;
                    mod_d   = modulus_in;
                end
            end
            StRun: begin
                if (last_k) begin
                    k_d = '0;
                    if (last_i) begin
                        i_d     = '0;
                        base_d  = '0;
                        drain_d = '0;
                        state_d = StDrain;
                    end else begin
                        i_d    = i_q + AddrOne;
                        base_d = base_q + (t_q << 1);
                    end
                end else begin
                    k_d = k_q + AddrOne;
                end
            end
            StDrain: begin
                // The last write of the stage lands in the final drain cycle, so the
                // next stage may read from the following cycle on.
                if (drain_end) begin
                    drain_d = '0;
                    if (last_stage) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                        stage_d = stage_q + AddrOne;
                        m_d     = m_q << 1;
                        t_d     = t_q >> 1;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            stage_q <= '0;
            m_q     <= '0;
            t_q     <= '0;
            i_q     <= '0;
            k_q     <= '0;
            base_q  <= '0;
            drain_q <= '0;
            mod_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            m_q     <= m_d;
            t_q     <= t_d;
            i_q     <= i_d;
            k_q     <= k_d;
            base_q  <= base_d;
            drain_q <= drain_d;
            mod_q   <= mod_d;
        end
    end

    // Addresses are forced to zero outside issue cycles, which also keeps the
    // invalid slots of the write-back delay line at zero.
    assign rd_en     = (state_q == StRun);
    assign rd_addr_a = rd_en ? (base_q + k_q) : '0;
    assign rd_addr_b = rd_en ? (base_q + k_q + t_q) : '0;
    assign tw_addr   = rd_en ? (m_q + i_q) : '0;
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign modulus   = mod_q;

    ntt_wb_delay #(
        .DEPTH (D),
        .AW    (LOG_N)
    ) u_wb_delay (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (rd_en),
        .in_addr_a  (rd_addr_a),
        .in_addr_b  (rd_addr_b),
        .out_valid  (wr_en),
        .out_addr_a (wr_addr_a),
        .out_addr_b (wr_addr_b)
    );

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb_ntt_stage_ctrl: directed bench for ntt_stage_ctrl at N=8, RD_LAT=1, BU_LAT=2.

`ifndef D_width
`define D_width 32
`endif

module tb_ntt_stage_ctrl;

    localparam int unsigned N      = 8;
    localparam int unsigned LOG_N  = 3;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned BU_LAT = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [`D_width-1:0] modulus_in;
    logic                busy;
    logic                done;
    logic                rd_en;
    logic [LOG_N-1:0]    rd_addr_a;
    logic [LOG_N-1:0]    rd_addr_b;
    logic [LOG_N-1:0]    tw_addr;
    logic [`D_width-1:0] modulus;
    logic                wr_en;
    logic [LOG_N-1:0]    wr_addr_a;
    logic [LOG_N-1:0]    wr_addr_b;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Hand-computed issue order (a, b, tw) for the three stages of N=8.
    int exp_a  [12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
    int exp_b  [12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
    int exp_tw [12] = '{1, 1, 1, 1,  2, 2, 3, 3,  4, 5, 6, 7};

    ntt_stage_ctrl #(
        .N      (N),
        .LOG_N  (LOG_N),
        .RD_LAT (RD_LAT),
        .BU_LAT (BU_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .modulus_in (modulus_in),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .tw_addr    (tw_addr),
        .modulus    (modulus),
        .wr_en      (wr_en),
        .wr_addr_a  (wr_addr_a),
        .wr_addr_b  (wr_addr_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rd_en"}, 32'(rd_en), 0);
        check({tag, ".rd_addr_a"}, 32'(rd_addr_a), 0);
        check({tag, ".rd_addr_b"}, 32'(rd_addr_b), 0);
        check({tag, ".tw_addr"}, 32'(tw_addr), 0);
        check({tag, ".wr_en"}, 32'(wr_en), 0);
        check({tag, ".wr_addr_a"}, 32'(wr_addr_a), 0);
        check({tag, ".wr_addr_b"}, 32'(wr_addr_b), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".modulus"}, 32'(modulus), 0);
    endtask

    // Starts one transform from IDLE and checks every cycle 1..22 against the table.
    // modulus_in is switched to alt_mod during the run; the latched value must not move.
    task automatic run_transform(input string tag, input logic [31:0] mod_val,
                                 input logic [31:0] alt_mod);
        int s, p, ri, wi;
        logic rd_x, wr_x;
        start      = 1'b1;
        modulus_in = mod_val;
        step();
        start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            if (c == 5) modulus_in = alt_mod;
            rd_x = 1'b0;
            wr_x = 1'b0;
            ri   = 0;
            wi   = 0;
            if (c >= 1 && c <= 21) begin
                s = (c - 1) / 7;
                p = (c - 1) % 7;
                if (p < 4) begin
                    rd_x = 1'b1;
                    ri   = s * 4 + p;
                end
            end
            if (c >= 4 && c <= 21) begin
                s = (c - 4) / 7;
                p = (c - 4) % 7;
                if (p < 4) begin
                    wr_x = 1'b1;
                    wi   = s * 4 + p;
                end
            end
            check($sformatf("%s.c%0d.rd_en", tag, c), 32'(rd_en), 32'(rd_x));
            check($sformatf("%s.c%0d.rd_a", tag, c), 32'(rd_addr_a), rd_x ? exp_a[ri] : 0);
            check($sformatf("%s.c%0d.rd_b", tag, c), 32'(rd_addr_b), rd_x ? exp_b[ri] : 0);
            check($sformatf("%s.c%0d.tw", tag, c), 32'(tw_addr), rd_x ? exp_tw[ri] : 0);
            check($sformatf("%s.c%0d.wr_en", tag, c), 32'(wr_en), 32'(wr_x));
            if (wr_x) begin
                check($sformatf("%s.c%0d.wr_a", tag, c), 32'(wr_addr_a), exp_a[wi]);
                check($sformatf("%s.c%0d.wr_b", tag, c), 32'(wr_addr_b), exp_b[wi]);
            end
            check($sformatf("%s.c%0d.busy", tag, c), 32'(busy), (c <= 21) ? 1 : 0);
            check($sformatf("%s.c%0d.done", tag, c), 32'(done), (c == 22) ? 1 : 0);
            check($sformatf("%s.c%0d.modulus", tag, c), 32'(modulus), mod_val);
            step();
        end
        check({tag, ".idle_busy"}, 32'(busy), 0);
        check({tag, ".idle_done"}, 32'(done), 0);
        check({tag, ".idle_modulus"}, 32'(modulus), mod_val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_at;
        int done_seen;
        int wr_seen;

        rst        = 1'b1;
        start      = 1'b0;
        modulus_in = '0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Full sequence, modulus held across a mid-run change of modulus_in.
        run_transform("run1", 32'd12289, 32'd7681);

        // start held high for 30 cycles: one run, then a second from IDLE at cycle 23.
        start      = 1'b1;
        modulus_in = 32'd3329;
        step();
        for (int c = 1; c <= 29; c++) begin
            if (c == 8) begin
                check("hold.c8.rd_a", 32'(rd_addr_a), 0);
                check("hold.c8.rd_b", 32'(rd_addr_b), 2);
                check("hold.c8.tw", 32'(tw_addr), 2);
            end
            check($sformatf("hold.c%0d.done", c), 32'(done), (c == 22) ? 1 : 0);
            check($sformatf("hold.c%0d.busy", c), 32'(busy), (c <= 21 || c >= 24) ? 1 : 0);
            step();
        end
        start   = 1'b0;
        done_at = -1;
        for (int c = 30; c < 80 && done_at < 0; c++) begin
            if (done) done_at = c;
            step();
        end
        check("hold.second_done_cycle", 32'(done_at), 45);
        step();
        step();
        check("hold.no_third_run", 32'(busy), 0);

        // Reset mid-run at cycle 10.
        start      = 1'b1;
        modulus_in = 32'd12289;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst       = 1'b0;
        done_seen = 0;
        wr_seen   = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) done_seen++;
            if (wr_en) wr_seen++;
            step();
        end
        check("midrst.no_done", 32'(done_seen), 0);
        check("midrst.no_wr", 32'(wr_seen), 0);

        run_transform("run2", 32'd7681, 32'd12289);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
